fifo_issue_arbiter: RTL and testbench

//  Round-robin arbiter sharing one downstream issue port among NUM_REQUESTERS fifo_queue read sides.

---
 rtl/fifo_arb_pkg.sv | 24 ++
 rtl/rr_priority_picker.sv | 38 +++
 rtl/fifo_issue_arbiter.sv | 146 ++++++++++++++
 tb/tb_fifo_issue_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_arb_pkg
//  Purpose  : Shared definitions for the fifo_issue_arbiter block.
//             Holds the issue FSM state encoding and the counter
//             saturation constant.
//  Revision : 1.0  initial release
// ============================================================================
package fifo_arb_pkg;

    // Issue stage FSM. IDLE means the output register is empty.
    // ISSUE means it holds a winner that is waiting for the downstream ack.
    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

    // Widest counter supported. Each counter slices its own width out of
    // this all-ones value to get its saturation value.
    localparam int unsigned  C_PERF_CNT_MAX_WIDTH = 64;
    localparam logic [63:0]  C_PERF_CNT_SAT       = '1;

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
//  Module   : rr_priority_picker
//  Purpose  : Combinational round-robin picker. Returns the first set bit of
//             'eligible' found by scanning ptr, ptr+1, ..., N-1, 0, ...
//             The wrap happens at N-1, so N does not need to be a power of 2.
//  Ports    : eligible  [N-1:0]   candidate requesters
//             ptr       [IDX-1:0] highest-priority index for this cycle
//             winner    [IDX-1:0] selected index (0 when none)
//             any_valid           at least one eligible requester
//  Revision : 1.0  initial release
// ============================================================================
module rr_priority_picker #(
    parameter int NUM_REQUESTERS        = 4,
    parameter int REQ_IDX_WIDTH_IN_BITS = 2
) (
    input  logic [NUM_REQUESTERS-1:0]        eligible,
    input  logic [REQ_IDX_WIDTH_IN_BITS-1:0] ptr,
    output logic [REQ_IDX_WIDTH_IN_BITS-1:0] winner,
    output logic                             any_valid
);

    // Walk the offsets from farthest to nearest. A later match overrides an
    // earlier one, so the smallest offset from ptr wins.
    always_comb begin
        winner    = '0;
        any_valid = |eligible;
        for (int k = NUM_REQUESTERS - 1; k >= 0; k--) begin
            for (int j = 0; j < NUM_REQUESTERS; j++) begin
                if (eligible[j] && (((int'(ptr) + k) % NUM_REQUESTERS) == j)) begin
                    winner = REQ_IDX_WIDTH_IN_BITS'(j);
                end
            end
        end
    end

endmodule : rr_priority_picker
`default_nettype wire

// File: rtl/fifo_issue_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_issue_arbiter
//  Purpose  : Round-robin arbiter that shares one registered downstream issue
//             port between NUM_REQUESTERS fifo read sides. The winning entry
//             is held in the output register until issue_ack_in. When another
//             requester is eligible, it streams back-to-back.
//  Ports    : clk_in, reset_in (async, active-high)
//             request_in[N*W], request_valid_in[N]  upstream entries
//             issue_ack_out[N]                      one-cycle pop pulse
//             request_out[W], request_valid_out,
//             grant_id_out[IDX]                     registered issue stage
//             issue_ack_in                          downstream consumed it
//             grant_count_out[N*C]                  saturating grant counters
//  Config   : FIFO_ARB_PERF_CNT_EN adds grant_count_out and its counters.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_issue_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQUESTERS             = 4,
    parameter int REQ_IDX_WIDTH_IN_BITS      = 2,
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 32,
    parameter int PERF_CNT_WIDTH_IN_BITS     = 16
) (
    input  logic                                                 clk_in,
    input  logic                                                 reset_in,
    input  logic [NUM_REQUESTERS*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in,
    input  logic [NUM_REQUESTERS-1:0]                            request_valid_in,
    output logic [NUM_REQUESTERS-1:0]                            issue_ack_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]                request_out,
    output logic                                                 request_valid_out,
    output logic [REQ_IDX_WIDTH_IN_BITS-1:0]                     grant_id_out,
`ifdef FIFO_ARB_PERF_CNT_EN
    output logic [NUM_REQUESTERS*PERF_CNT_WIDTH_IN_BITS-1:0]     grant_count_out,
`endif
    input  logic                                                 issue_ack_in
);

    localparam logic [REQ_IDX_WIDTH_IN_BITS-1:0] c_last_idx =
        REQ_IDX_WIDTH_IN_BITS'(NUM_REQUESTERS - 1);

    arb_state_t                              r_state;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]   r_request;
    logic                                    r_request_valid;
    logic [REQ_IDX_WIDTH_IN_BITS-1:0]        r_grant_id;
    logic [NUM_REQUESTERS-1:0]               r_issue_ack;
    logic [NUM_REQUESTERS-1:0]               r_ack_mask;
    logic [REQ_IDX_WIDTH_IN_BITS-1:0]        r_ptr;

    logic [NUM_REQUESTERS-1:0]               w_eligible;
    logic [REQ_IDX_WIDTH_IN_BITS-1:0]        w_winner;
    logic                                    w_any_valid;
    logic [NUM_REQUESTERS-1:0]               w_winner_onehot;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]   w_winner_payload;
    logic [REQ_IDX_WIDTH_IN_BITS-1:0]        w_ptr_next;

    // A requester is popped at the end of the cycle in which its ack pulse is
    // high, so its valid in that cycle still describes the entry just taken.
    // The mask is loaded together with the ack pulse and has the same value.
    assign w_eligible = request_valid_in & ~r_ack_mask;

    rr_priority_picker #(
        .NUM_REQUESTERS        (NUM_REQUESTERS),
        .REQ_IDX_WIDTH_IN_BITS (REQ_IDX_WIDTH_IN_BITS)
    ) u_picker (
        .eligible  (w_eligible),
        .ptr       (r_ptr),
        .winner    (w_winner),
        .any_valid (w_any_valid)
    );

    assign w_winner_onehot  = {{(NUM_REQUESTERS-1){1'b0}}, 1'b1} << w_winner;
    assign w_winner_payload = request_in[w_winner*SINGLE_ENTRY_WIDTH_IN_BITS +: SINGLE_ENTRY_WIDTH_IN_BITS];
    assign w_ptr_next       = (w_winner == c_last_idx) ? '0 : w_winner + 1'b1;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state         <= IDLE;
            r_request       <= '0;
            r_request_valid <= 1'b0;
            r_grant_id      <= '0;
            r_issue_ack     <= '0;
            r_ack_mask      <= '0;
            r_ptr           <= '0;
        end else begin
            r_issue_ack <= '0;
            r_ack_mask  <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any_valid) begin
                        r_request       <= w_winner_payload;
                        r_grant_id      <= w_winner;
                        r_request_valid <= 1'b1;
                        r_issue_ack     <= w_winner_onehot;
                        r_ack_mask      <= w_winner_onehot;
                        r_ptr           <= w_ptr_next;
                        r_state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue_ack_in) begin
                        if (w_any_valid) begin
                            r_request   <= w_winner_payload;
                            r_grant_id  <= w_winner;
                            r_issue_ack <= w_winner_onehot;
                            r_ack_mask  <= w_winner_onehot;
                            r_ptr       <= w_ptr_next;
                        end else begin
                            r_request       <= '0;
                            r_request_valid <= 1'b0;
                            r_state         <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign issue_ack_out     = r_issue_ack;
    assign request_out       = r_request;
    assign request_valid_out = r_request_valid;
    assign grant_id_out      = r_grant_id;

`ifdef FIFO_ARB_PERF_CNT_EN
    localparam logic [PERF_CNT_WIDTH_IN_BITS-1:0] c_cnt_sat =
        C_PERF_CNT_SAT[PERF_CNT_WIDTH_IN_BITS-1:0];

    for (genvar gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_perf_cnt
        logic [PERF_CNT_WIDTH_IN_BITS-1:0] r_count;

        always_ff @(posedge clk_in or posedge reset_in) begin
            if (reset_in) begin
                r_count <= '0;
            end else if (r_issue_ack[gi] && (r_count != c_cnt_sat)) begin
                r_count <= r_count + 1'b1;
            end
        end

        assign grant_count_out[gi*PERF_CNT_WIDTH_IN_BITS +: PERF_CNT_WIDTH_IN_BITS] = r_count;
    end
`endif

endmodule : fifo_issue_arbiter
`default_nettype wire

// File: tb/tb_fifo_issue_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_issue_arbiter
//  Purpose  : Directed self-checking bench for fifo_issue_arbiter.
//             Inputs change 1 ns after a rising edge. Outputs are sampled at
//             the same point, after the edge has settled.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_issue_arbiter;

    localparam int N   = 4;
    localparam int IDX = 2;
    localparam int W   = 32;
`ifdef FIFO_ARB_PERF_CNT_EN
    localparam int C   = 4;
`else
    localparam int C   = 16;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [N*W-1:0]   request_in;
    logic [N-1:0]     request_valid_in;
    logic [N-1:0]     issue_ack_out;
    logic [W-1:0]     request_out;
    logic             request_valid_out;
    logic [IDX-1:0]   grant_id_out;
    logic             issue_ack_in;
`ifdef FIFO_ARB_PERF_CNT_EN
    logic [N*C-1:0]   grant_count_out;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_issue_arbiter #(
        .NUM_REQUESTERS             (N),
        .REQ_IDX_WIDTH_IN_BITS      (IDX),
        .SINGLE_ENTRY_WIDTH_IN_BITS (W),
        .PERF_CNT_WIDTH_IN_BITS     (C)
    ) dut (
        .clk_in            (clk),
        .reset_in          (rst),
        .request_in        (request_in),
        .request_valid_in  (request_valid_in),
        .issue_ack_out     (issue_ack_out),
        .request_out       (request_out),
        .request_valid_out (request_valid_out),
        .grant_id_out      (grant_id_out),
`ifdef FIFO_ARB_PERF_CNT_EN
        .grant_count_out   (grant_count_out),
`endif
        .issue_ack_in      (issue_ack_in)
    );

    function automatic logic [W-1:0] payload(input int i);
        return 32'hA000_0000 + W'(i);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        request_valid_in = '0;
        issue_ack_in     = 1'b0;
        for (int i = 0; i < N; i++) request_in[i*W +: W] = payload(i);
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({request_valid_out, grant_id_out, issue_ack_out, request_out} !== '0) begin
            errors++;
            $display("FAIL reset_state: got vld=%0b id=%0d ack=%b data=%h, expected all zero",
                     request_valid_out, grant_id_out, issue_ack_out, request_out);
        end
    endtask

    task automatic test_reset_mid_issue();
        do_reset();
        request_valid_in = 4'b1010;
        issue_ack_in     = 1'b0;
        step();
        checks++;
        if (request_valid_out !== 1'b1 || grant_id_out !== 2'd1) begin
            errors++;
            $display("FAIL mid_issue_setup: got vld=%0b id=%0d, expected vld=1 id=1",
                     request_valid_out, grant_id_out);
        end
        step();
        step();
        // Assert reset between edges; the outputs must clear without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({request_valid_out, grant_id_out, issue_ack_out, request_out} !== '0) begin
            errors++;
            $display("FAIL async_reset: got vld=%0b id=%0d ack=%b data=%h, expected all zero",
                     request_valid_out, grant_id_out, issue_ack_out, request_out);
        end
        step();
        rst = 1'b0;
        step();
        // The pointer is back at 0, so requester 1 is the lowest eligible and wins.
        checks++;
        if (request_valid_out !== 1'b1 || grant_id_out !== 2'd1 || issue_ack_out !== 4'b0010
            || request_out !== payload(1)) begin
            errors++;
            $display("FAIL post_reset_grant: got vld=%0b id=%0d ack=%b data=%h, expected 1 1 0010 %h",
                     request_valid_out, grant_id_out, issue_ack_out, request_out, payload(1));
        end
    endtask

    task automatic test_round_robin();
        logic [IDX-1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [N-1:0]   exp_ack;
        do_reset();
        request_valid_in = 4'b1111;
        issue_ack_in     = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            exp_ack = 4'b0001 << exp_id[k];
            checks++;
            if (request_valid_out !== 1'b1 || grant_id_out !== exp_id[k] || issue_ack_out !== exp_ack
                || request_out !== payload(int'(exp_id[k]))) begin
                errors++;
                $display("FAIL round_robin[%0d]: got vld=%0b id=%0d ack=%b data=%h, expected 1 %0d %b %h",
                         k, request_valid_out, grant_id_out, issue_ack_out, request_out,
                         exp_id[k], exp_ack, payload(int'(exp_id[k])));
            end
        end
    endtask

    task automatic test_single_stream();
        logic prev_ack = 1'b0;
        int   grants   = 0;
        do_reset();
        request_valid_in = 4'b0100;
        issue_ack_in     = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (request_valid_out !== ((k % 2) == 0) || (prev_ack && issue_ack_out[2])
                || (issue_ack_out & 4'b1011) !== 4'b0000) begin
                errors++;
                $display("FAIL single_stream[%0d]: got vld=%0b ack=%b prev_ack2=%0b, expected vld=%0b no back-to-back ack",
                         k, request_valid_out, issue_ack_out, prev_ack, ((k % 2) == 0));
            end
            if (issue_ack_out[2]) grants++;
            prev_ack = issue_ack_out[2];
        end
        checks++;
        if (grants != 4) begin
            errors++;
            $display("FAIL single_stream_count: got %0d grants, expected 4", grants);
        end
    endtask

    task automatic test_hold();
        do_reset();
        request_in[1*W +: W] = 32'hDEAD_BEEF;
        request_valid_in     = 4'b0010;
        issue_ack_in         = 1'b0;
        step();
        checks++;
        if (issue_ack_out !== 4'b0010 || request_out !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL hold_first: got ack=%b data=%h, expected 0010 deadbeef",
                     issue_ack_out, request_out);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (request_out !== 32'hDEAD_BEEF || issue_ack_out !== 4'b0000
                || grant_id_out !== 2'd1 || request_valid_out !== 1'b1) begin
                errors++;
                $display("FAIL hold[%0d]: got vld=%0b id=%0d ack=%b data=%h, expected 1 1 0000 deadbeef",
                         k, request_valid_out, grant_id_out, issue_ack_out, request_out);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        request_valid_in = 4'b0100;
        issue_ack_in     = 1'b0;
        step();
        // Requester 2 was granted, so the pointer is now 3.
        request_valid_in = 4'b1001;
        issue_ack_in     = 1'b1;
        step();
        checks++;
        if (grant_id_out !== 2'd3 || issue_ack_out !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_first: got id=%0d ack=%b, expected id=3 ack=1000",
                     grant_id_out, issue_ack_out);
        end
        step();
        checks++;
        if (grant_id_out !== 2'd0 || issue_ack_out !== 4'b0001 || request_valid_out !== 1'b1) begin
            errors++;
            $display("FAIL wrap_second: got vld=%0b id=%0d ack=%b, expected vld=1 id=0 ack=0001",
                     request_valid_out, grant_id_out, issue_ack_out);
        end
    endtask

    task automatic test_idle_ack_ignored();
        do_reset();
        request_valid_in = 4'b0000;
        issue_ack_in     = 1'b1;
        step();
        step();
        checks++;
        if (request_valid_out !== 1'b0 || issue_ack_out !== 4'b0000 || request_out !== '0) begin
            errors++;
            $display("FAIL idle_ack: got vld=%0b ack=%b data=%h, expected 0 0000 0",
                     request_valid_out, issue_ack_out, request_out);
        end
    endtask

`ifdef FIFO_ARB_PERF_CNT_EN
    task automatic test_perf_counters();
        do_reset();
        request_valid_in = 4'b0001;
        issue_ack_in     = 1'b1;
        step();
        step();
        checks++;
        if (grant_count_out[0 +: C] !== 4'd1) begin
            errors++;
            $display("FAIL perf_first: got count0=%0d, expected 1", grant_count_out[0 +: C]);
        end
        // 40 cycles in total give 20 grants, and the counter stops at 15.
        for (int k = 0; k < 38; k++) step();
        request_valid_in = 4'b0000;
        step();
        step();
        checks++;
        if (grant_count_out !== 16'h000F) begin
            errors++;
            $display("FAIL perf_saturate: got counts=%h, expected 000f", grant_count_out);
        end
    endtask
`endif

    initial begin
        rst              = 1'b1;
        request_in       = '0;
        request_valid_in = '0;
        issue_ack_in     = 1'b0;
        test_reset();
        test_reset_mid_issue();
        test_round_robin();
        test_single_stream();
        test_hold();
        test_wrap();
        test_idle_ack_ignored();
`ifdef FIFO_ARB_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fifo_issue_arbiter
`default_nettype wire
